// File: rtl/memory_cycle_scheduler_pkg.sv
// Shared chipset definitions for the memory cycle scheduler: FSM state encoding
// and default timing constants for a 50 MHz core clock.
package memory_cycle_scheduler_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACCESS  = 3'd1,
    HOLD    = 3'd2,
    REFRESH = 3'd3,
    ARMED   = 3'd4
  } state_t;

  localparam int REFRESH_INTERVAL_DEF = 390;  // 7.8 us at 50 MHz
  localparam int MAX_PENDING_DEF      = 4;
  localparam int ACK_TIMEOUT_DEF      = 63;

endpackage

// File: rtl/memory_cycle_scheduler_refresh_timer.sv
// Free-running refresh interval counter with a saturating pending-refresh count.
// Pending updates one cycle after a wrap or ack; no backpressure (ack is a qualified pulse).
module memory_cycle_scheduler_refresh_timer
  import memory_cycle_scheduler_pkg::*;
#(
  parameter int REFRESH_INTERVAL = REFRESH_INTERVAL_DEF,
  parameter int MAX_PENDING      = MAX_PENDING_DEF
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       refresh_ack,
  output logic [2:0] pending,
  output logic [2:0] pending_nxt
);

  localparam int CNT_W = $clog2(REFRESH_INTERVAL);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_INTERVAL - 1);
  localparam logic [2:0] PEND_MAX = 3'(MAX_PENDING);

  logic [CNT_W-1:0] interval_q, interval_d;
  logic [2:0]       pending_q, pending_d;
  logic             wrap;

  always_comb begin
    wrap       = (interval_q == CNT_LAST);
    interval_d = wrap ? '0 : interval_q + CNT_W'(1);
    pending_d  = pending_q;
    // A wrap coinciding with an ack cancels out.
    if (wrap && !refresh_ack) begin
      if (pending_q != PEND_MAX) pending_d = pending_q + 3'd1;
    end else if (!wrap && refresh_ack && pending_q != 3'd0) begin
      pending_d = pending_q - 3'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      interval_q <= '0;
      pending_q  <= '0;
    end else begin
      interval_q <= interval_d;
      pending_q  <= pending_d;
    end
  end

  assign pending     = pending_q;
  assign pending_nxt = pending_d;

endmodule

// File: rtl/memory_cycle_scheduler.sv
// Sequences bus RAM cycles and periodic refresh onto the SDRAM back end.
// Request issued one cycle after the strobe edge; bus held via memory_access_ready until ram_ack.
module memory_cycle_scheduler
  import memory_cycle_scheduler_pkg::*;
#(
  parameter int REFRESH_INTERVAL = REFRESH_INTERVAL_DEF,
  parameter int MAX_PENDING      = MAX_PENDING_DEF,
  parameter int ACK_TIMEOUT      = ACK_TIMEOUT_DEF
) (
  input  logic clock,
  input  logic reset_n,
  input  logic memory_read_n,
  input  logic memory_write_n,
  input  logic ram_address_select_n,
  output logic memory_access_ready,
  output logic ram_request,
  output logic ram_write,
  input  logic ram_ack,
  output logic refresh_request,
  input  logic refresh_ack,
  output logic timeout_error
);

  localparam int TMO_W = ($clog2(ACK_TIMEOUT + 1) > 6) ? $clog2(ACK_TIMEOUT + 1) : 6;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);
  localparam logic [2:0] PEND_MAX = 3'(MAX_PENDING);

  state_t           state_q, state_d;
  logic             strb_idle_q, strb_idle_d;
  logic             ram_request_q, ram_request_d;
  logic             ram_write_q, ram_write_d;
  logic             refresh_request_q, refresh_request_d;
  logic             timeout_error_q, timeout_error_d;
  logic             deferred_q, deferred_d;
  logic             def_write_q, def_write_d;
  logic             entry_max_q, entry_max_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  logic       strb_idle, start, access_write, tmo_expire, ref_ack;
  logic [2:0] pending, pending_nxt;

  assign strb_idle    = memory_read_n & memory_write_n;
  assign start        = ~strb_idle & ~ram_address_select_n & strb_idle_q;
  assign access_write = ~memory_write_n & memory_read_n;  // both strobes low reads
  assign tmo_expire   = (state_q == ACCESS) && !ram_ack && (tmo_q == TMO_LAST);
  assign ref_ack      = refresh_ack && (state_q == REFRESH);

  memory_cycle_scheduler_refresh_timer #(
    .REFRESH_INTERVAL(REFRESH_INTERVAL),
    .MAX_PENDING     (MAX_PENDING)
  ) u_refresh_timer (
    .clock      (clock),
    .reset_n    (reset_n),
    .refresh_ack(ref_ack),
    .pending    (pending),
    .pending_nxt(pending_nxt)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q           <= IDLE;
      strb_idle_q       <= 1'b0;
      ram_request_q     <= 1'b0;
      ram_write_q       <= 1'b0;
      refresh_request_q <= 1'b0;
      timeout_error_q   <= 1'b0;
      deferred_q        <= 1'b0;
      def_write_q       <= 1'b0;
      entry_max_q       <= 1'b0;
      tmo_q             <= '0;
    end else begin
      state_q           <= state_d;
      strb_idle_q       <= strb_idle_d;
      ram_request_q     <= ram_request_d;
      ram_write_q       <= ram_write_d;
      refresh_request_q <= refresh_request_d;
      timeout_error_q   <= timeout_error_d;
      deferred_q        <= deferred_d;
      def_write_q       <= def_write_d;
      entry_max_q       <= entry_max_d;
      tmo_q             <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = (pending < PEND_MAX) ? ACCESS : REFRESH;
        else if (pending != 3'd0) state_d = REFRESH;
      end
      ACCESS:  if (ram_ack || tmo_expire) state_d = HOLD;
      HOLD:    if (strb_idle) state_d = IDLE;
      REFRESH: begin
        if (ref_ack) begin
          if (deferred_q || start) state_d = ARMED;
          else if (pending_nxt != 3'd0 && entry_max_q) state_d = REFRESH;
          else state_d = IDLE;
        end
      end
      ARMED:   state_d = ACCESS;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    strb_idle_d       = strb_idle;
    ram_request_d     = (state_d == ACCESS);
    refresh_request_d = (state_d == REFRESH);
    ram_write_d       = ram_write_q;
    timeout_error_d   = timeout_error_q | tmo_expire;
    deferred_d        = deferred_q;
    def_write_d       = def_write_q;
    entry_max_d       = entry_max_q;
    tmo_d             = (state_q == ACCESS) ? tmo_q + TMO_W'(1) : '0;

    if (state_q == IDLE && state_d == ACCESS) ram_write_d = access_write;
    if (state_q == ARMED) begin
      ram_write_d = def_write_q;
      deferred_d  = 1'b0;
    end
    // A strobe edge that cannot be served now is remembered across the refresh.
    if (start && ((state_q == IDLE && state_d == REFRESH) || state_q == REFRESH)) begin
      deferred_d  = 1'b1;
      def_write_d = access_write;
    end
    if (state_q == IDLE && state_d == REFRESH) entry_max_d = (pending == PEND_MAX);

    memory_access_ready = 1'b1;
    if ((state_q == IDLE && start) ||
        (state_q == REFRESH && (start || deferred_q)) ||
        state_q == ACCESS || state_q == ARMED)
      memory_access_ready = 1'b0;
  end

  assign ram_request     = ram_request_q;
  assign ram_write       = ram_write_q;
  assign refresh_request = refresh_request_q;
  assign timeout_error   = timeout_error_q;

endmodule

// File: tb/tb_memory_cycle_scheduler.sv
// Directed bench for memory_cycle_scheduler: stimulus pushes expected back-end
// transactions, a negedge monitor retires them as requests complete.
`timescale 1ns/1ps
module tb_memory_cycle_scheduler;

  logic clock = 1'b0;
  logic reset_n = 1'b1;
  logic memory_read_n = 1'b1, memory_write_n = 1'b1, ram_address_select_n = 1'b1;
  logic ram_ack = 1'b0, refresh_ack = 1'b0;
  logic memory_access_ready, ram_request, ram_write, refresh_request, timeout_error;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    bit is_ref;
    bit wr;
    int len;
  } exp_t;
  exp_t sb[$];

  always #5 clock = ~clock;

  memory_cycle_scheduler dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .memory_read_n       (memory_read_n),
    .memory_write_n      (memory_write_n),
    .ram_address_select_n(ram_address_select_n),
    .memory_access_ready (memory_access_ready),
    .ram_request         (ram_request),
    .ram_write           (ram_write),
    .ram_ack             (ram_ack),
    .refresh_request     (refresh_request),
    .refresh_ack         (refresh_ack),
    .timeout_error       (timeout_error)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic expect_op(input bit r, input bit w, input int l);
    exp_t e;
    e.is_ref = r;
    e.wr     = w;
    e.len    = l;
    sb.push_back(e);
  endtask

  task automatic retire(input bit r, input bit w, input int l);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_op: got ref=%0d wr=%0d len=%0d required none", r, w, l);
    end else begin
      e = sb.pop_front();
      chk("op_kind", 32'(r), 32'(e.is_ref));
      chk("op_write", 32'(w), 32'(e.wr));
      chk("op_length", 32'(l), 32'(e.len));
    end
  endtask

  bit req_prev = 0, ref_prev = 0, req_wr = 0;
  int req_len = 0, ref_len = 0;

  always @(negedge clock) begin
    if (!reset_n) begin
      req_prev = 0; ref_prev = 0; req_len = 0; ref_len = 0;
    end else begin
      if (ram_request) begin
        if (!req_prev) req_wr = ram_write;
        req_len++;
      end else if (req_prev) begin
        retire(1'b0, req_wr, req_len);
        req_len = 0;
      end
      if (refresh_request) ref_len++;
      else if (ref_prev) begin
        retire(1'b1, 1'b0, ref_len);
        ref_len = 0;
      end
      req_prev = ram_request;
      ref_prev = refresh_request;
    end
  end

  initial begin
    bit any;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_ready", 32'(memory_access_ready), 1);
    chk("rst_ram_request", 32'(ram_request), 0);
    chk("rst_ram_write", 32'(ram_write), 0);
    chk("rst_refresh_request", 32'(refresh_request), 0);
    chk("rst_timeout_error", 32'(timeout_error), 0);
    tick(); tick();
    reset_n = 1'b1;
    cyc = 0;
    tick(); tick(); tick();

    // Read hit, ack on the third request cycle.
    memory_read_n = 1'b0; ram_address_select_n = 1'b0;
    expect_op(1'b0, 1'b0, 3);
    #2 chk("rd_ready_strobe", 32'(memory_access_ready), 0);
    tick();
    #2 chk("rd_ready_wait", 32'(memory_access_ready), 0);
    chk("rd_write_bit", 32'(ram_write), 0);
    tick();
    tick();
    ram_ack = 1'b1;
    #2 chk("rd_ready_ack", 32'(memory_access_ready), 0);
    tick();
    ram_ack = 1'b0;
    #2 chk("rd_ready_done", 32'(memory_access_ready), 1);
    chk("rd_request_done", 32'(ram_request), 0);
    memory_read_n = 1'b1; ram_address_select_n = 1'b1;
    tick(); tick();

    // Both strobes low is a read.
    memory_read_n = 1'b0; memory_write_n = 1'b0; ram_address_select_n = 1'b0;
    expect_op(1'b0, 1'b0, 1);
    tick();
    ram_ack = 1'b1;
    tick();
    ram_ack = 1'b0;
    memory_read_n = 1'b1; memory_write_n = 1'b1; ram_address_select_n = 1'b1;
    #2 chk("both_ready_hold", 32'(memory_access_ready), 1);
    tick(); tick();

    // Plain write.
    memory_write_n = 1'b0; ram_address_select_n = 1'b0;
    expect_op(1'b0, 1'b1, 2);
    tick(); tick();
    ram_ack = 1'b1;
    tick();
    ram_ack = 1'b0;
    memory_write_n = 1'b1; ram_address_select_n = 1'b1;
    tick(); tick();

    // Non-RAM strobe, then a late select while the strobe stays low.
    memory_read_n = 1'b0; ram_address_select_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2 chk("nonram_ready", 32'(memory_access_ready), 1);
      chk("nonram_request", 32'(ram_request), 0);
      tick();
    end
    ram_address_select_n = 1'b0;
    #2 chk("nonram_late_select", 32'(memory_access_ready), 1);
    tick();
    chk("nonram_late_request", 32'(ram_request), 0);
    memory_read_n = 1'b1; ram_address_select_n = 1'b1;
    tick();
    ram_ack = 1'b1;
    tick();
    ram_ack = 1'b0;
    #2 chk("stray_ack_request", 32'(ram_request), 0);

    // Idle refresh after the first interval wrap.
    while (!refresh_request && cyc < 500) tick();
    chk("idle_ref_rise", 32'(refresh_request), 1);
    chk("idle_ref_cycle", 32'(cyc), 391);
    expect_op(1'b1, 1'b0, 3);
    tick(); tick();
    refresh_ack = 1'b1;
    tick();
    refresh_ack = 1'b0;
    #2 chk("idle_ref_drop", 32'(refresh_request), 0);
    any = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (refresh_request) any = 1;
    end
    chk("idle_ref_quiet", 32'(any), 0);

    // Forced refresh: hold off ack until four refreshes are pending, then write.
    while (!refresh_request && cyc < 900) tick();
    chk("forced_ref_cycle", 32'(cyc), 781);
    while (cyc < 1952) tick();
    memory_write_n = 1'b0; ram_address_select_n = 1'b0;
    #2 chk("forced_ready_strobe", 32'(memory_access_ready), 0);
    chk("forced_no_access", 32'(ram_request), 0);
    tick();
    refresh_ack = 1'b1;
    expect_op(1'b1, 1'b0, 1173);
    expect_op(1'b0, 1'b1, 2);
    #2 chk("forced_ready_refresh", 32'(memory_access_ready), 0);
    tick();
    refresh_ack = 1'b0;
    #2 chk("forced_ready_armed", 32'(memory_access_ready), 0);
    chk("forced_ref_dropped", 32'(refresh_request), 0);
    chk("forced_armed_request", 32'(ram_request), 0);
    tick();
    #2 chk("forced_request", 32'(ram_request), 1);
    chk("forced_write_bit", 32'(ram_write), 1);
    chk("forced_ready_access", 32'(memory_access_ready), 0);
    tick();
    ram_ack = 1'b1;
    #2 chk("forced_ready_ack", 32'(memory_access_ready), 0);
    tick();
    ram_ack = 1'b0;
    #2 chk("forced_ready_done", 32'(memory_access_ready), 1);
    memory_write_n = 1'b1; ram_address_select_n = 1'b1;

    // Three refreshes remain pending.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 20 && !refresh_request; i++) tick();
      chk("drain_ref_seen", 32'(refresh_request), 1);
      expect_op(1'b1, 1'b0, 1);
      refresh_ack = 1'b1;
      tick();
      refresh_ack = 1'b0;
    end
    any = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (refresh_request) any = 1;
    end
    chk("drain_quiet", 32'(any), 0);

    // Ack timeout.
    chk("tmo_clear_before", 32'(timeout_error), 0);
    memory_read_n = 1'b0; ram_address_select_n = 1'b0;
    expect_op(1'b0, 1'b0, 63);
    for (int i = 0; i < 100 && !timeout_error; i++) tick();
    #2 chk("tmo_flag", 32'(timeout_error), 1);
    chk("tmo_request", 32'(ram_request), 0);
    chk("tmo_ready_hold", 32'(memory_access_ready), 1);
    memory_read_n = 1'b1; ram_address_select_n = 1'b1;
    tick(); tick(); tick();
    chk("tmo_sticky", 32'(timeout_error), 1);

    // Asynchronous reset in the middle of an access.
    memory_read_n = 1'b0; ram_address_select_n = 1'b0;
    tick();
    #1 chk("arst_pre_request", 32'(ram_request), 1);
    #1 reset_n = 1'b0;
    #1 chk("arst_request", 32'(ram_request), 0);
    chk("arst_ready", 32'(memory_access_ready), 1);
    chk("arst_timeout", 32'(timeout_error), 0);
    memory_read_n = 1'b1; ram_address_select_n = 1'b1;
    tick(); tick();
    reset_n = 1'b1;
    tick(); tick(); tick();
    chk("scoreboard_drained", 32'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
